rtc_bus_scheduler: RTL and testbench
====================================

# rtc_bus_scheduler

Sequences all traffic on the shared RTC register bus for the clock/display subsystem. Once per frame, at vertical-blanking start, it sweeps the 11 displayed RTC/timer registers. Each value it captures is written to the display snapshot store, which the VGA interface latches as its datos inputs. Between reads it interleaves user-edit writes from the programming FSM. It also produces the frame-locked cursor blink.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles to wait for bus_ack before aborting a transaction.
- BLINK_FRAMES, 30: number of completed sweeps per blink toggle.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- vblank_start  in  1  one-cycle pulse on the first cycle of pixel row 480
- write_req  in  1  edit request; held high until write_done
- write_addr  in  8  RTC register address; stable while write_req is high
- write_data  in  8  BCD data; stable while write_req is high
- write_done  out  1  one-cycle pulse when the write transaction ends
- bus_req  out  1  bus transaction request
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  8  bus address
- bus_wdata  out  8  bus write data
- bus_rdata  in  8  read data; valid in the bus_ack cycle
- bus_ack  in  1  one-cycle completion pulse from the bus master
- snap_we  out  1  snapshot store write strobe
- snap_idx  out  4  snapshot index 0..10
- snap_data  out  8  captured BCD byte
- frame_done  out  1  one-cycle pulse at the end of a sweep
- blink  out  1  cursor blink phase
- timeout_err  out  1  sticky; any transaction timed out
- overrun_err  out  1  sticky; vblank_start arrived during a sweep

## Operation
- Read table (snap_idx -> bus_addr):
  - 0..7 -> 0x21..0x28 (seconds, minutes, hours, date, month, year, weekday, week number)
  - 8..10 -> 0x41..0x43 (timer seconds, minutes, hours)
- FSM states: IDLE, ARB, RD_REQ, RD_CAP, WR_REQ, WR_DONE, FIN.
- IDLE:
  - vblank_start -> ARB with idx = 0 and sweep = 1.
  - Otherwise, write_req -> WR_REQ with sweep = 0.
  - If both occur in the same cycle, vblank wins. The write is taken at the first ARB.
- ARB:
  - write_req high -> WR_REQ (writes have priority between reads).
  - Else if sweep = 1 and idx <= 10 -> RD_REQ.
  - Else if sweep = 1 -> FIN.
  - Else -> IDLE.
- RD_REQ:
  - bus_req = 1, bus_we = 0, bus_addr = table[idx].
  - On bus_ack, register bus_rdata and go to RD_CAP.
- RD_CAP:
  - snap_we = 1 with the captured idx and data.
  - Increment idx, then go to ARB.
- WR_REQ:
  - bus_req = 1, bus_we = 1, with write_addr and write_data registered on entry.
  - On bus_ack -> WR_DONE.
- WR_DONE:
  - write_done = 1, then go to ARB.
  - write_req is not sampled in this cycle. A registered requester drops it in time for ARB.
- FIN:
  - frame_done = 1 and sweep = 0, then go to ARB, so a pending write is still served.
- Timeout:
  - A per-transaction counter starts at 0 on entering RD_REQ or WR_REQ.
  - Reaching TIMEOUT without bus_ack sets timeout_err and drops bus_req.
  - For a read: no snap_we. Increment idx and go to ARB.
  - For a write: go to WR_DONE (write_done still pulses).
- vblank_start while sweep = 1 sets overrun_err. The current sweep continues unchanged; no restart.
- Blink:
  - The frame counter counts frame_done pulses.
  - At BLINK_FRAMES it wraps to 0 and blink toggles.
- bus_addr, bus_we and bus_wdata are registered. They are held stable for the whole time bus_req is high.

## Timing
- Reset values:
  - Every output is 0: bus_req, bus_we, bus_addr, bus_wdata, snap_we, snap_idx, snap_data, write_done, frame_done, blink, timeout_err, overrun_err.
  - FSM is in IDLE; idx, frame counter and timeout counter are 0.
- Reset mid-transaction: bus_req drops immediately (asynchronously). No snap_we or write_done is issued.
- bus_req rises in the cycle after entering a REQ state. It falls in the cycle after bus_ack.
- An ack coinciding with the first cycle of bus_req is legal.
- Read cost is ack latency + 2 cycles; write cost is ack latency + 2 cycles.
- A sweep with 1-cycle ack and no writes: vblank_start at cycle 0, first bus_req at cycle 2, frame_done at cycle 36.
- Sweep must complete within the 36 000-cycle blanking interval. Overrun is reported, not corrected.

## Test plan
- Sweep:
  - Stimulus: bus model acks after 1 cycle with rdata = addr ^ 0x5A; pulse vblank_start.
  - Required: 11 snap_we pulses, idx 0..10, data 0x7B..0x72 then 0x1B..0x19; one frame_done; no errors.
- Write interleave:
  - Stimulus: write_req (0x22, 0x45) raised during the read of idx 3.
  - Required: bus write to 0x22 = 0x45 occurs between the idx 3 and idx 4 reads; write_done pulses once; all 11 reads still complete.
- Idle write:
  - Stimulus: write_req (0x41, 0x30) with no vblank.
  - Required: one bus write; write_done pulses once; no snap_we; no frame_done.
- Timeout:
  - Stimulus: bus withholds ack for address 0x25.
  - Required: bus_req drops after 255 cycles; no snap_we for idx 4; timeout_err = 1; sweep finishes with 10 captures.
- Blink and overrun:
  - Stimulus: 60 sweeps, then a vblank_start injected mid-sweep.
  - Required: blink toggles at the 30th and 60th frame_done; overrun_err = 1.
- Reset:
  - Stimulus: assert reset during a WR_REQ.
  - Required: all outputs 0 the same cycle; no write_done is issued.

Source files
------------

// File: rtl/rtc_bus_scheduler.sv
// Shared RTC register bus sequencer: per-frame snapshot sweep of 11 registers,
// interleaved user-edit writes, per-transaction timeout and frame-locked blink.
module rtc_bus_scheduler #(
  parameter int TIMEOUT      = 255,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank_start,
  input  logic       write_req,
  input  logic [7:0] write_addr,
  input  logic [7:0] write_data,
  output logic       write_done,
  output logic       bus_req,
  output logic       bus_we,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_ack,
  output logic       snap_we,
  output logic [3:0] snap_idx,
  output logic [7:0] snap_data,
  output logic       frame_done,
  output logic       blink,
  output logic       timeout_err,
  output logic       overrun_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [2:0] {IDLE, ARB, RD_REQ, RD_CAP, WR_REQ, WR_DONE, FIN} state_t;

  state_t          state;
  logic [3:0]      idx;
  logic            sweep;
  logic [TW-1:0]   tcnt;
  logic [FW-1:0]   fcnt;

  // Snapshot slot to RTC address: clock/calendar block then timer block.
  function automatic logic [7:0] rd_addr(input logic [3:0] i);
    if (i < 4'd8) return 8'h21 + {4'd0, i};
    else          return 8'h41 + {4'd0, i} - 8'd8;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      sweep       <= 1'b0;
      tcnt        <= '0;
      fcnt        <= '0;
      write_done  <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      snap_we     <= 1'b0;
      snap_idx    <= '0;
      snap_data   <= '0;
      frame_done  <= 1'b0;
      blink       <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      snap_we    <= 1'b0;
      write_done <= 1'b0;
      frame_done <= 1'b0;
      // A new frame arriving mid-sweep is only reported; the sweep carries on.
      if (vblank_start && sweep) overrun_err <= 1'b1;

      case (state)
        IDLE: begin
          if (vblank_start) begin
            state <= ARB;
            idx   <= '0;
            sweep <= 1'b1;
          end else if (write_req) begin
            state     <= WR_REQ;
            sweep     <= 1'b0;
            bus_req   <= 1'b1;
            bus_we    <= 1'b1;
            bus_addr  <= write_addr;
            bus_wdata <= write_data;
            tcnt      <= '0;
          end
        end
        ARB: begin
          if (write_req) begin
            state     <= WR_REQ;
            bus_req   <= 1'b1;
            bus_we    <= 1'b1;
            bus_addr  <= write_addr;
            bus_wdata <= write_data;
            tcnt      <= '0;
          end else if (sweep && idx <= 4'd10) begin
            state    <= RD_REQ;
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= rd_addr(idx);
            tcnt     <= '0;
          end else if (sweep) begin
            state <= FIN;
          end else begin
            state <= IDLE;
          end
        end
        RD_REQ: begin
          if (bus_ack) begin
            bus_req   <= 1'b0;
            snap_we   <= 1'b1;
            snap_idx  <= idx;
            snap_data <= bus_rdata;
            state     <= RD_CAP;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // Abandon this slot; its snapshot keeps the previous frame's value.
            bus_req     <= 1'b0;
            timeout_err <= 1'b1;
            idx         <= idx + 4'd1;
            state       <= ARB;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        RD_CAP: begin
          idx   <= idx + 4'd1;
          state <= ARB;
        end
        WR_REQ: begin
          if (bus_ack) begin
            bus_req    <= 1'b0;
            write_done <= 1'b1;
            state      <= WR_DONE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            bus_req     <= 1'b0;
            timeout_err <= 1'b1;
            write_done  <= 1'b1;
            state       <= WR_DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WR_DONE: state <= ARB;
        FIN: begin
          frame_done <= 1'b1;
          sweep      <= 1'b0;
          if (fcnt == FW'(BLINK_FRAMES - 1)) begin
            fcnt  <= '0;
            blink <= ~blink;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
          state <= ARB;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Scoreboard bench for rtc_bus_scheduler: a reference model queues expected
// snapshot/write/frame events, a monitor pops and compares them as they occur.
module tb_rtc_bus_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vblank_start = 1'b0;
  logic       write_req = 1'b0;
  logic [7:0] write_addr = 8'h00;
  logic [7:0] write_data = 8'h00;
  logic       write_done;
  logic       bus_req, bus_we;
  logic [7:0] bus_addr, bus_wdata;
  logic [7:0] bus_rdata = 8'h00;
  logic       bus_ack = 1'b0;
  logic       snap_we;
  logic [3:0] snap_idx;
  logic [7:0] snap_data;
  logic       frame_done, blink, timeout_err, overrun_err;

  rtc_bus_scheduler #(.TIMEOUT(255), .BLINK_FRAMES(30)) dut (
    .clk(clk), .reset(reset), .vblank_start(vblank_start),
    .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
    .write_done(write_done), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .snap_we(snap_we), .snap_idx(snap_idx),
    .snap_data(snap_data), .frame_done(frame_done), .blink(blink),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  localparam int K_SNAP = 0, K_WR = 1, K_WD = 2, K_FD = 3;
  typedef struct { int kind; int a; int b; } ev_t;
  ev_t expq[$];

  int errors = 0, checks = 0;
  int cyc = 0;

  // bus model configuration (written by the main process only)
  logic [7:0] key = 8'h5A;
  bit  rand_lat = 1'b0, hold_writes = 1'b0;
  int  hang_addr = -1;
  int  hang_len = 0;
  // write requester configuration
  int  wr_seq = 0, wr_trig = -1;
  logic [7:0] wr_a = 8'h00, wr_d = 8'h00;
  // monitor state
  bit  timing_on = 1'b0;
  int  first_req_cyc = -1, fd_cyc = -1;
  int  nfr = 0, wd_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_ev(input int k, input int a, input int b);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL event: got unexpected kind=%0d a=0x%0h b=0x%0h, expected none", k, a, b);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.a != a || e.b != b) begin
        errors++;
        $display("FAIL event: got kind=%0d a=0x%0h b=0x%0h, expected kind=%0d a=0x%0h b=0x%0h",
                 k, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  function automatic int tbl(input int i);
    return (i < 8) ? (8'h21 + i) : (8'h41 + i - 8);
  endfunction

  task automatic push(input int k, input int a, input int b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    expq.push_back(e);
  endtask

  // Expected events of one sweep: write inserted after slot wj, slot skip lost.
  task automatic push_sweep(input logic [7:0] kv, input int wj, input int wa, input int wd,
                            input int skip);
    for (int i = 0; i <= 10; i++) begin
      if (i != skip) push(K_SNAP, i, tbl(i) ^ int'(kv));
      if (i == wj) begin
        push(K_WR, wa, wd);
        push(K_WD, 0, 0);
      end
    end
    push(K_FD, 0, 0);
  endtask

  task automatic arm_write(input int trig, input logic [7:0] a, input logic [7:0] d);
    wr_a = a; wr_d = d; wr_trig = trig;
    wr_seq++;
  endtask

  int t0 = 0;
  task automatic pulse_vblank();
    @(negedge clk);
    t0 = cyc;
    vblank_start = 1'b1;
    @(negedge clk);
    vblank_start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk({name, " pending events"}, expq.size(), 0);
    expq.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " bus_req"}, bus_req, 0);
    chk({tag, " bus_we"}, bus_we, 0);
    chk({tag, " bus_addr"}, bus_addr, 0);
    chk({tag, " bus_wdata"}, bus_wdata, 0);
    chk({tag, " snap_we/idx/data"}, {snap_we, snap_idx, snap_data}, 0);
    chk({tag, " write_done/frame_done"}, {write_done, frame_done}, 0);
    chk({tag, " blink/timeout/overrun"}, {blink, timeout_err, overrun_err}, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus master model: acks after a (possibly random) wait, rdata = addr ^ key.
  initial begin
    int bcnt = 0, lat = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset || !bus_req) begin
        bus_ack = 1'b0;
        bcnt = 0;
      end else if (bus_ack) begin
        bus_ack = 1'b0;
      end else begin
        if (bcnt == 0) lat = rand_lat ? int'($urandom_range(0, 3)) : 0;
        if ((!bus_we && int'(bus_addr) == hang_addr) || (bus_we && hold_writes)) begin
          if (!bus_we) hang_len++;
          bcnt++;
        end else if (bcnt >= lat) begin
          bus_ack = 1'b1;
          bus_rdata = bus_addr ^ key;
        end else begin
          bcnt++;
        end
      end
    end
  end

  // Edit requester: raises write_req when armed (immediately or during a read
  // of a trigger address) and drops it on write_done.
  initial begin
    int served = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        write_req = 1'b0;
      end else if (write_req && write_done) begin
        write_req = 1'b0;
      end else if (!write_req && served != wr_seq &&
                   (wr_trig < 0 || (bus_req && !bus_we && int'(bus_addr) == wr_trig))) begin
        write_addr = wr_a;
        write_data = wr_d;
        write_req  = 1'b1;
        served     = wr_seq;
      end
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (!timing_on) begin
      first_req_cyc = -1;
      fd_cyc = -1;
    end
    if (reset) begin
      nfr = 0;
    end else begin
      if (timing_on && bus_req && first_req_cyc < 0) first_req_cyc = cyc;
      if (snap_we) check_ev(K_SNAP, int'(snap_idx), int'(snap_data));
      if (bus_req && bus_we && bus_ack) check_ev(K_WR, int'(bus_addr), int'(bus_wdata));
      if (write_done) begin
        wd_count++;
        check_ev(K_WD, 0, 0);
      end
      if (frame_done) begin
        if (timing_on && fd_cyc < 0) fd_cyc = cyc;
        nfr++;
        check_ev(K_FD, 0, 0);
        chk("blink phase at frame_done", blink, (nfr / 30) % 2);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int wd0, n, j;
    logic [7:0] wa, wdv;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Plain sweep, 1-cycle ack, rdata = addr ^ 0x5A
    key = 8'h5A;
    push_sweep(key, -1, 0, 0, -1);
    timing_on = 1'b1;
    pulse_vblank();
    drain("sweep");
    chk("first bus_req cycle", first_req_cyc - t0, 2);
    chk("frame_done cycle", fd_cyc - t0, 36);
    timing_on = 1'b0;
    chk("sweep timeout_err", timeout_err, 0);
    chk("sweep overrun_err", overrun_err, 0);

    // Write raised during the idx 3 read
    arm_write(8'h24, 8'h22, 8'h45);
    push_sweep(key, 3, 8'h22, 8'h45, -1);
    pulse_vblank();
    drain("interleave");
    chk("interleave write_done count", wd_count, 1);

    // Write with no sweep
    arm_write(-1, 8'h41, 8'h30);
    push(K_WR, 8'h41, 8'h30);
    push(K_WD, 0, 0);
    drain("idle write");
    chk("idle write_done count", wd_count, 2);

    // Randomized sweeps: random ack latency, data key and write slot
    rand_lat = 1'b1;
    for (int r = 0; r < 8; r++) begin
      key = 8'($urandom);
      j   = int'($urandom_range(0, 10));
      wa  = 8'($urandom);
      wdv = 8'($urandom);
      arm_write(tbl(j), wa, wdv);
      push_sweep(key, j, int'(wa), int'(wdv), -1);
      pulse_vblank();
      drain("random sweep");
    end
    rand_lat = 1'b0;
    key = 8'h5A;

    // Blink: 60 sweeps from a fresh reset
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    for (int s = 1; s <= 60; s++) begin
      push_sweep(key, -1, 0, 0, -1);
      pulse_vblank();
      drain("blink sweep");
      if (s == 29) chk("blink before 30th frame", blink, 0);
      if (s == 30) chk("blink after 30th frame", blink, 1);
    end
    chk("blink after 60th frame", blink, 0);
    chk("frame count", nfr, 60);

    // Overrun: second vblank mid-sweep, sweep continues unchanged
    chk("overrun_err before", overrun_err, 0);
    push_sweep(key, -1, 0, 0, -1);
    pulse_vblank();
    repeat (12) @(negedge clk);
    pulse_vblank();
    drain("overrun sweep");
    chk("overrun_err after", overrun_err, 1);

    // Timeout on address 0x25 (idx 4)
    chk("timeout_err before", timeout_err, 0);
    hang_addr = 8'h25;
    hang_len = 0;
    push_sweep(key, -1, 0, 0, 4);
    pulse_vblank();
    drain("timeout sweep");
    chk("bus_req cycles on hung read", hang_len, 255);
    chk("timeout_err after", timeout_err, 1);
    hang_addr = -1;

    // Reset in the middle of a write transaction
    hold_writes = 1'b1;
    arm_write(-1, 8'h33, 8'h44);
    n = 0;
    while (!(bus_req && bus_we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("write started before reset", int'(bus_req && bus_we), 1);
    repeat (3) @(negedge clk);
    wd0 = wd_count;
    #1 reset = 1'b1;
    #1 check_outputs_zero("async reset");
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    hold_writes = 1'b0;
    repeat (20) @(negedge clk);
    chk("write_done after reset", wd_count, wd0);
    chk("stray events after reset", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
